// File: rtl/conv_pkg.sv
// Shared types, default widths and flatten/saturate helpers for the streaming
// multi-channel convolution accumulator.
package conv_pkg;

  localparam int DEF_IN_DW  = 8;
  localparam int DEF_W_DW   = 8;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_OUT_DW = 16;

  // Working width of the saturation helper; wide enough for any ACC_W+1 sum.
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // LSB offset of pixel (ch,r,c) inside the packed image bus.
  function automatic int pix_off(input int ch, input int r, input int c,
                                 input int in_h, input int in_w, input int in_dw);
    return ((ch * in_h + r) * in_w + c) * in_dw;
  endfunction

  // LSB offset of weight (ch,kr,kc) inside the packed weight bus.
  function automatic int wgt_off(input int ch, input int kr, input int kc,
                                 input int k_h, input int k_w, input int w_dw);
    return ((ch * k_h + kr) * k_w + kc) * w_dw;
  endfunction

  // Clamp a sign-extended value to the signed range of an out_dw-bit result.
  function automatic logic signed [SAT_W-1:0] sat_clip(input logic signed [SAT_W-1:0] v,
                                                       input int out_dw);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (out_dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/conv_stream_acc_window_mac.sv
// Combinational K_H x K_W dot product of unsigned pixels with signed weights,
// sign-extended into the accumulator width.
module window_mac
  import conv_pkg::*;
#(
  parameter int K_H   = 3,
  parameter int K_W   = 3,
  parameter int IN_DW = DEF_IN_DW,
  parameter int W_DW  = DEF_W_DW,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [K_H*K_W*IN_DW-1:0] win_pix,
  input  logic [K_H*K_W*W_DW-1:0]  win_wgt,
  output logic signed [ACC_W-1:0]  dot
);

  // One extra bit so a zero-extended pixel stays non-negative when signed.
  localparam int PROD_W = IN_DW + W_DW + 1;

  logic signed [PROD_W-1:0] pix_ext;
  logic signed [PROD_W-1:0] wgt_ext;
  logic signed [PROD_W-1:0] prod;

  // NOTE: every variable written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    dot     = '0;
    pix_ext = '0;
    wgt_ext = '0;
    prod    = '0;
    for (int i = 0; i < K_H * K_W; i++) begin
      pix_ext = $signed(PROD_W'(win_pix[i*IN_DW +: IN_DW]));
      wgt_ext = {{(PROD_W - W_DW){win_wgt[i*W_DW + W_DW - 1]}}, win_wgt[i*W_DW +: W_DW]};
      prod    = pix_ext * wgt_ext;
      dot     = dot + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    end
  end

endmodule

// File: rtl/conv_stream_acc.sv
// Time-multiplexed KxK valid-mode convolution: one channel window per cycle,
// bias + optional ReLU + saturation, row-major output stream with backpressure.
module conv_stream_acc
  import conv_pkg::*;
#(
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int IN_H   = 16,
  parameter int IN_W   = 15,
  parameter int IN_CH  = 10,
  parameter int IN_DW  = DEF_IN_DW,
  parameter int W_DW   = DEF_W_DW,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_DW = DEF_OUT_DW,
  localparam int OUT_H = IN_H - K_H + 1,
  localparam int OUT_W = IN_W - K_W + 1,
  localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [IN_CH*IN_H*IN_W*IN_DW-1:0] in_img,
  input  logic [IN_CH*K_H*K_W*W_DW-1:0]   w_conv,
  input  logic [ACC_W-1:0]                bias,
  input  logic                            relu_en,
  output logic [OUT_DW-1:0]               out_data,
  output logic [ROW_W-1:0]                out_row,
  output logic [COL_W-1:0]                out_col,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            done
);

  localparam int CH_W     = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int IMG_BITS = IN_CH * IN_H * IN_W * IN_DW;
  localparam int WGT_BITS = IN_CH * K_H * K_W * W_DW;
  localparam int IMG_IW   = $clog2(IMG_BITS);
  localparam int WGT_IW   = $clog2(WGT_BITS);

  state_t state, state_nxt;

  logic [ROW_W-1:0]        row;
  logic [COL_W-1:0]        col;
  logic [CH_W-1:0]         ch_cnt;
  logic signed [ACC_W-1:0] acc;

  logic [K_H*K_W*IN_DW-1:0] win_pix;
  logic [K_H*K_W*W_DW-1:0]  win_wgt;
  logic [IMG_IW-1:0]        pix_idx;
  logic [WGT_IW-1:0]        wgt_idx;
  logic signed [ACC_W-1:0]  mac_dot;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W:0]    sum_wide;
  logic [OUT_DW-1:0]        out_next;

  logic ch_last, col_last, pix_last, out_free;

  assign ch_last  = (ch_cnt == CH_W'(IN_CH - 1));
  assign col_last = (col == COL_W'(OUT_W - 1));
  assign pix_last = col_last && (row == ROW_W'(OUT_H - 1));
  assign out_free = !out_valid || out_ready;

  // Gather the current channel's window straight from the stable input buses.
  always_comb begin
    win_pix = '0;
    win_wgt = '0;
    pix_idx = '0;
    wgt_idx = '0;
    for (int kr = 0; kr < K_H; kr++) begin
      for (int kc = 0; kc < K_W; kc++) begin
        pix_idx = IMG_IW'(pix_off(int'(ch_cnt), int'(row) + kr, int'(col) + kc,
                                  IN_H, IN_W, IN_DW));
        wgt_idx = WGT_IW'(wgt_off(int'(ch_cnt), kr, kc, K_H, K_W, W_DW));
        win_pix[(kr*K_W + kc)*IN_DW +: IN_DW] = in_img[pix_idx +: IN_DW];
        win_wgt[(kr*K_W + kc)*W_DW +: W_DW]   = w_conv[wgt_idx +: W_DW];
      end
    end
  end

  window_mac #(
    .K_H   (K_H),
    .K_W   (K_W),
    .IN_DW (IN_DW),
    .W_DW  (W_DW),
    .ACC_W (ACC_W)
  ) u_window_mac (
    .win_pix (win_pix),
    .win_wgt (win_wgt),
    .dot     (mac_dot)
  );

  // Bias is added one bit wider than the accumulator so it cannot wrap; ReLU
  // precedes saturation so a clamped negative becomes exactly zero.
  always_comb begin
    acc_next = acc + mac_dot;
    sum_wide = {acc_next[ACC_W-1], acc_next} + {bias[ACC_W-1], bias};
    if (relu_en && sum_wide[ACC_W]) sum_wide = '0;
    out_next = OUT_DW'(sat_clip({{(SAT_W - ACC_W - 1){sum_wide[ACC_W]}}, sum_wide}, OUT_DW));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_CALC;
      ST_CALC:  if (ch_last && out_free && pix_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_valid && out_ready) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_CALC) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row       <= '0;
      col       <= '0;
      ch_cnt    <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            row    <= '0;
            col    <= '0;
            ch_cnt <= '0;
            acc    <= '0;
          end
        end
        ST_CALC: begin
          if (!ch_last) begin
            acc    <= acc_next;
            ch_cnt <= ch_cnt + CH_W'(1);
          end else if (out_free) begin
            // A load in the same cycle as a transfer keeps out_valid high.
            out_data  <= out_next;
            out_row   <= row;
            out_col   <= col;
            out_valid <= 1'b1;
            acc       <= '0;
            ch_cnt    <= '0;
            if (pix_last) begin
              row <= '0;
              col <= '0;
            end else if (col_last) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_stream_acc.sv
// Randomised scoreboard bench for conv_stream_acc on a 2-channel 4x4 image
// with a 3x3 kernel (2x2 output map).
module tb_conv_stream_acc;

  localparam int K       = 3;
  localparam int IN_H    = 4;
  localparam int IN_W    = 4;
  localparam int IN_CH   = 2;
  localparam int IN_DW   = 8;
  localparam int W_DW    = 8;
  localparam int ACC_W   = 24;
  localparam int OUT_DW  = 16;
  localparam int OUT_H   = IN_H - K + 1;
  localparam int OUT_W   = IN_W - K + 1;
  localparam int OUT_PIX = OUT_H * OUT_W;
  localparam int IMG_BITS = IN_CH * IN_H * IN_W * IN_DW;
  localparam int WGT_BITS = IN_CH * K * K * W_DW;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [IMG_BITS-1:0]  in_img;
  logic [WGT_BITS-1:0]  w_conv;
  logic [ACC_W-1:0]     bias;
  logic                 relu_en;
  logic [OUT_DW-1:0]    out_data;
  logic [0:0]           out_row;
  logic [0:0]           out_col;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic                 done;

  conv_stream_acc #(
    .K_H(K), .K_W(K), .IN_H(IN_H), .IN_W(IN_W), .IN_CH(IN_CH),
    .IN_DW(IN_DW), .W_DW(W_DW), .ACC_W(ACC_W), .OUT_DW(OUT_DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_img(in_img), .w_conv(w_conv),
    .bias(bias), .relu_en(relu_en), .out_data(out_data), .out_row(out_row),
    .out_col(out_col), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int data;
    int row;
    int col;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   hs_count = 0;

  int img[IN_CH][IN_H][IN_W];
  int wt[IN_CH][K][K];
  int bias_v;
  bit relu_v;
  logic [IMG_BITS+WGT_BITS+ACC_W:0] snap;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: direct valid-mode convolution over the whole map, row-major.
  task automatic apply_and_predict();
    int s;
    for (int ch = 0; ch < IN_CH; ch++)
      for (int r = 0; r < IN_H; r++)
        for (int c = 0; c < IN_W; c++)
          in_img[((ch*IN_H + r)*IN_W + c)*IN_DW +: IN_DW] = IN_DW'(img[ch][r][c]);
    for (int ch = 0; ch < IN_CH; ch++)
      for (int kr = 0; kr < K; kr++)
        for (int kc = 0; kc < K; kc++)
          w_conv[((ch*K + kr)*K + kc)*W_DW +: W_DW] = W_DW'(wt[ch][kr][kc]);
    bias    = ACC_W'(bias_v);
    relu_en = relu_v;
    snap    = {in_img, w_conv, bias, relu_en};
    for (int orow = 0; orow < OUT_H; orow++)
      for (int ocol = 0; ocol < OUT_W; ocol++) begin
        s = 0;
        for (int ch = 0; ch < IN_CH; ch++)
          for (int kr = 0; kr < K; kr++)
            for (int kc = 0; kc < K; kc++)
              s += img[ch][orow+kr][ocol+kc] * wt[ch][kr][kc];
        s += bias_v;
        if (relu_v && s < 0) s = 0;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        exp_q.push_back('{data: s, row: orow, col: ocol});
      end
  endtask

  task automatic set_img_const(input int v);
    for (int ch = 0; ch < IN_CH; ch++)
      for (int r = 0; r < IN_H; r++)
        for (int c = 0; c < IN_W; c++) img[ch][r][c] = v;
  endtask

  task automatic set_img_ramp();
    for (int ch = 0; ch < IN_CH; ch++)
      for (int r = 0; r < IN_H; r++)
        for (int c = 0; c < IN_W; c++) img[ch][r][c] = ch*16 + r*4 + c;
  endtask

  task automatic set_wt(input bit rnd, input int v);
    for (int ch = 0; ch < IN_CH; ch++)
      for (int kr = 0; kr < K; kr++)
        for (int kc = 0; kc < K; kc++)
          wt[ch][kr][kc] = rnd ? int'($urandom_range(0, 255)) - 128 : v;
  endtask

  // Monitor: samples just before the rising edge that would complete a transfer.
  always begin
    @(negedge clk);
    #3;
    if (rst_n && busy && ({in_img, w_conv, bias, relu_en} !== snap)) begin
      total++;
      bad++;
      $display("FAIL input_stability: inputs changed while busy (t=%0t)", $time);
    end
    if (rst_n && out_valid && out_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got row=%0d col=%0d data=%0d, required no output",
                 out_row, out_col, $signed(out_data));
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", longint'($signed(out_data)), mon_e.data);
        check("out_row", out_row, mon_e.row);
        check("out_col", out_col, mon_e.col);
      end
    end
  end

  // Runs one job; k counts rising edges after the one that sampled start.
  task automatic run_job(input int stall, input bit rnd_ready, input bit restart,
                         output int first_k, output int done_k);
    int k;
    int stall_left;
    bit stalled;
    logic [OUT_DW-1:0] hold_d;
    logic [0:0] hold_r, hold_c;
    int hs_before;
    hs_before  = hs_count;
    first_k    = -1;
    done_k     = -1;
    stall_left = 0;
    stalled    = 1'b0;
    hold_d     = '0;
    hold_r     = '0;
    hold_c     = '0;
    out_ready  = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    k = 0;
    while (done_k < 0 && k < 400) begin
      if (out_valid && first_k < 0) first_k = k;
      if (stall_left > 0) begin
        check("stall_hold", ((out_data == hold_d) && (out_row == hold_r) &&
                             (out_col == hold_c) && out_valid && busy), 1);
        stall_left--;
        if (stall_left == 0) out_ready = 1'b1;
      end else if (stall > 0 && !stalled && out_valid) begin
        stalled    = 1'b1;
        out_ready  = 1'b0;
        hold_d     = out_data;
        hold_r     = out_row;
        hold_c     = out_col;
        stall_left = stall;
      end else if (rnd_ready) begin
        out_ready = 1'($urandom_range(0, 1));
      end
      if (restart) start = (k == 3);
      @(negedge clk);
      k++;
      if (done) done_k = k;
    end
    out_ready = 1'b1;
    // In the DONE cycle a start must be ignored.
    start = restart;
    if (done_k < 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done within %0d cycles, required done", k);
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse_width", done, 0);
    check("busy_after_done", busy, 0);
    check("output_count", hs_count - hs_before, OUT_PIX);
    check("queue_empty", exp_q.size(), 0);
  endtask

  int fk, dk;

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    out_ready = 1'b1;
    in_img  = '0;
    w_conv  = '0;
    bias    = '0;
    relu_en = 1'b0;
    snap    = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_col", out_col, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic: all ones -> 18 everywhere, with cycle timing.
    set_img_const(1); set_wt(0, 1); bias_v = 0; relu_v = 0;
    apply_and_predict();
    run_job(0, 0, 0, fk, dk);
    check("first_valid_edge", fk, IN_CH);
    check("done_edge", dk, OUT_PIX*IN_CH + 1);

    // Negative weights, ReLU, negative bias.
    set_wt(0, -1); relu_v = 0; apply_and_predict(); run_job(0, 0, 0, fk, dk);
    relu_v = 1; apply_and_predict(); run_job(0, 0, 0, fk, dk);
    set_wt(0, 1); bias_v = -20; relu_v = 0; apply_and_predict(); run_job(0, 0, 0, fk, dk);

    // Saturation both ways, then ReLU over a negative saturation.
    set_img_const(255); set_wt(0, 127); bias_v = 0; relu_v = 0;
    apply_and_predict(); run_job(0, 0, 0, fk, dk);
    set_wt(0, -128); apply_and_predict(); run_job(0, 0, 0, fk, dk);
    relu_v = 1; apply_and_predict(); run_job(0, 0, 0, fk, dk);

    // Backpressure: 10 blocked cycles; one cycle is absorbed by channel slack.
    set_img_ramp(); set_wt(0, 1); bias_v = 0; relu_v = 0;
    apply_and_predict();
    run_job(10, 0, 0, fk, dk);
    check("stall_done_edge", dk, OUT_PIX*IN_CH + 1 + 10 - (IN_CH - 1));

    // Restart attempts mid-run and in the DONE cycle are ignored.
    set_wt(1, 0); bias_v = 5;
    apply_and_predict();
    run_job(0, 0, 1, fk, dk);

    // Asynchronous reset mid-run, then a clean run.
    set_wt(1, 0); bias_v = -100; relu_v = 0;
    apply_and_predict();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_done", done, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    apply_and_predict();
    run_job(0, 0, 0, fk, dk);
    check("post_reset_done_edge", dk, OUT_PIX*IN_CH + 1);

    // Random weights, bias, ReLU and out_ready on the ramp image.
    for (int j = 0; j < 6; j++) begin
      set_img_ramp();
      set_wt(1, 0);
      bias_v = int'($urandom_range(0, 32'h00FF_FFFF)) - 32'sh0080_0000;
      if (j < 2) bias_v = int'($urandom_range(0, 4000)) - 2000;
      relu_v = 1'($urandom_range(0, 1));
      apply_and_predict();
      run_job(0, 1, 0, fk, dk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
